// File: rtl/core_run_pkg.sv
//------------------------------------------------------------------------------
// Module   : core_run_pkg
// Brief    : Shared state encoding and width limits for the core run control
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package core_run_pkg;

  // Supported range for the number of core channels
  localparam int MIN_CORES  = 1;
  localparam int MAX_CORES  = 8;

  // Supported range for the single-step retire counter width
  localparam int MIN_STEP_W = 1;
  localparam int MAX_STEP_W = 32;

  // Per-channel run state; the encoding is visible to debug tooling, so keep it fixed
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } run_state_e;

endpackage : core_run_pkg

`default_nettype wire

// File: rtl/core_run_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : core_run_ctrl_if
// Brief    : Control/status bundle between a sequencer and core_run_ctrl
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface core_run_ctrl_if #(
  parameter int N_CORES = 2,
  parameter int STEP_W  = 8
);

  logic [N_CORES-1:0] start;
  logic [N_CORES-1:0] halt_req;
  logic [N_CORES-1:0] resume;
  logic               step_mode;
  logic [STEP_W-1:0]  step_cnt;
  logic [N_CORES-1:0] retire;
  logic [N_CORES-1:0] pipe_empty;
  logic [N_CORES-1:0] active;
  logic [N_CORES-1:0] halted;
  logic               any_active;

  // Sequencer side: issues commands, observes channel status
  modport master (
    output start, halt_req, resume, step_mode, step_cnt, retire, pipe_empty,
    input  active, halted, any_active
  );

  // Controller side
  modport slave (
    input  start, halt_req, resume, step_mode, step_cnt, retire, pipe_empty,
    output active, halted, any_active
  );

endinterface : core_run_ctrl_if

`default_nettype wire

// File: rtl/core_run_ch.sv
//------------------------------------------------------------------------------
// Module   : core_run_ch
// Brief    : Single core channel run/drain/halt FSM with single-step counter
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module core_run_ch
  import core_run_pkg::*;
#(
  parameter int STEP_W = 8
) (
  input  wire logic              clk,
  input  wire logic              rstn,
  input  wire logic              start,
  input  wire logic              halt_req,
  input  wire logic              resume,
  input  wire logic              step_mode,
  input  wire logic [STEP_W-1:0] step_cnt,
  input  wire logic              retire,
  input  wire logic              pipe_empty,
  output logic                   active,
  output logic                   halted
);

  run_state_e        r_state;
  logic [STEP_W-1:0] r_cnt;
  logic              r_armed;
  logic              r_active;
  logic              r_halted;

  // Channel FSM, step counter and registered Moore outputs.
  // r_active/r_halted are loaded with the decode of the state being entered,
  // so they always match r_state exactly.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_armed  <= 1'b0;
      r_active <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            // Launch is always free-running; a coincident halt goes straight to drain
            r_armed <= 1'b0;
            if (halt_req) begin
              r_state  <= ST_DRAIN;
              r_active <= 1'b0;
            end else begin
              r_state  <= ST_RUN;
              r_active <= 1'b1;
            end
          end
        end

        ST_RUN: begin
          // Counter only moves while armed, and saturates at zero
          if (r_armed && retire && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
          end
          // The exhausted count is seen one cycle after the last retire
          if (halt_req || (r_armed && (r_cnt == '0))) begin
            r_state  <= ST_DRAIN;
            r_active <= 1'b0;
          end
        end

        ST_DRAIN: begin
          if (pipe_empty) begin
            r_state  <= ST_HALTED;
            r_halted <= 1'b1;
          end
        end

        ST_HALTED: begin
          // A pending halt request blocks the restart entirely
          if (resume && !halt_req) begin
            r_halted <= 1'b0;
            if (step_mode) begin
              r_cnt   <= step_cnt;
              r_armed <= 1'b1;
              // A zero-length step never issues: drain immediately
              if (step_cnt == '0) begin
                r_state <= ST_DRAIN;
              end else begin
                r_state  <= ST_RUN;
                r_active <= 1'b1;
              end
            end else begin
              r_armed  <= 1'b0;
              r_state  <= ST_RUN;
              r_active <= 1'b1;
            end
          end
        end

        default: begin
          r_state  <= ST_IDLE;
          r_active <= 1'b0;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  assign active = r_active;
  assign halted = r_halted;

endmodule : core_run_ch

`default_nettype wire

// File: rtl/core_run_ctrl.sv
//------------------------------------------------------------------------------
// Module   : core_run_ctrl
// Brief    : N independent core run-control channels plus any_active summary
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module core_run_ctrl
  import core_run_pkg::*;
#(
  parameter int N_CORES = 2,   // MIN_CORES..MAX_CORES
  parameter int STEP_W  = 8    // MIN_STEP_W..MAX_STEP_W
) (
  input  wire logic       clk,
  input  wire logic       rstn,
  core_run_ctrl_if.slave  bus
);

  logic [N_CORES-1:0] w_active;
  logic [N_CORES-1:0] w_halted;

  // One fully independent channel per core
  for (genvar i = 0; i < N_CORES; i++) begin : g_ch
    core_run_ch #(
      .STEP_W (STEP_W)
    ) u_ch (
      .clk        (clk),
      .rstn       (rstn),
      .start      (bus.start[i]),
      .halt_req   (bus.halt_req[i]),
      .resume     (bus.resume[i]),
      .step_mode  (bus.step_mode),
      .step_cnt   (bus.step_cnt),
      .retire     (bus.retire[i]),
      .pipe_empty (bus.pipe_empty[i]),
      .active     (w_active[i]),
      .halted     (w_halted[i])
    );
  end : g_ch

  assign bus.active     = w_active;
  assign bus.halted     = w_halted;
  // Pure OR of the registered per-channel bits, no extra pipeline stage
  assign bus.any_active = |w_active;

endmodule : core_run_ctrl

`default_nettype wire

// File: doc/core_run_ctrl.md
CORE_RUN_CTRL -- requirements
Module: core_run_ctrl

Interface
REQ-001 Parameter N_CORES, default 2, number of independent core channels (1..8).
REQ-002 Parameter STEP_W, default 8, width of the single-step retire counter.
REQ-003 clk  input  1  clock, all state updates on rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 start  input  N_CORES  per-channel launch pulse from IDLE.
REQ-006 halt_req  input  N_CORES  per-channel halt request, level or pulse.
REQ-007 resume  input  N_CORES  per-channel restart pulse from HALTED.
REQ-008 step_mode  input  1  when high, resume loads the step counter instead of running freely.
REQ-009 step_cnt  input  STEP_W  instructions to retire per step, sampled on resume.
REQ-010 retire  input  N_CORES  per-channel instruction-retired pulse.
REQ-011 pipe_empty  input  N_CORES  per-channel pipeline drained indication.
REQ-012 active  output  N_CORES  per-channel issue enable, high only in RUN.
REQ-013 halted  output  N_CORES  per-channel high only in HALTED.
REQ-014 any_active  output  1  OR of active.

Function
REQ-015 Each channel SHALL run an independent FSM with states IDLE, RUN, DRAIN, HALTED; outputs SHALL be Moore, decoded from registered state only.
REQ-016 IDLE: start -> RUN next cycle; halt_req with start SHALL go to DRAIN (halt wins).
REQ-017 RUN: halt_req -> DRAIN; step counter reaching zero -> DRAIN; otherwise stay RUN; start ignored.
REQ-018 DRAIN: active low; pipe_empty high -> HALTED next cycle; all other inputs ignored.
REQ-019 HALTED: resume with halt_req low -> RUN; resume with halt_req high SHALL stay HALTED; start ignored.
REQ-020 On resume with step_mode=1 the channel SHALL load step_cnt and set step_armed; with step_mode=0 step_armed SHALL clear.
REQ-021 While RUN and step_armed, each retire pulse SHALL decrement the counter by 1; counter reaching 0 SHALL cause RUN->DRAIN in the following cycle; counter SHALL never wrap below 0.
REQ-022 resume with step_mode=1 and step_cnt=0 SHALL go HALTED->DRAIN directly, never asserting active.
REQ-023 retire pulses outside RUN, or in RUN with step_armed low, SHALL not modify the counter.
REQ-024 Launch from IDLE via start SHALL clear step_armed (free run).
REQ-025 Channels SHALL not interact; simultaneous events on different channels SHALL be handled in the same cycle.
REQ-026 any_active SHALL be combinational OR of registered active bits, zero added latency.

Reset
REQ-027 rstn low SHALL force every channel to IDLE, counter 0, step_armed 0, active 0, halted 0, any_active 0, asynchronously.
REQ-028 Reset asserted mid-RUN or mid-DRAIN SHALL abandon the operation with no further output activity; deassertion SHALL leave all channels in IDLE awaiting start.

Structure
REQ-029 State encoding (2-bit IDLE=0, RUN=1, DRAIN=2, HALTED=3) and width limits SHALL live in shared package core_run_pkg.
REQ-030 One sub-module core_run_ch SHALL implement a single channel FSM plus counter; core_run_ctrl SHALL instantiate N_CORES copies via generate and form any_active.

Verification
REQ-031 Reset release, start[0] pulse -> active[0]=1 one cycle later, active[1]=0, any_active=1.
REQ-032 Channel 1 RUN, halt_req[1] pulse, pipe_empty[1] low 3 cycles then high -> active[1]=0 next cycle, halted[1]=1 exactly one cycle after pipe_empty rises.
REQ-033 Channel 0 HALTED, step_mode=1, step_cnt=3, resume, 3 retire pulses -> active[0] high until cycle after third retire, then DRAIN, then HALTED.
REQ-034 step_cnt=0 with resume in step mode -> active never asserted, HALTED regained after pipe_empty.
REQ-035 start and halt_req same cycle in IDLE -> DRAIN, active stays 0; resume and halt_req same cycle in HALTED -> stays HALTED.
REQ-036 N_CORES=4, rstn asserted mid-RUN on all channels -> all outputs 0 immediately, IDLE after release, no activity until start.
